// File: rtl/bk_pipe_addsub.sv
// bk_pipe_addsub: three-stage pipelined Brent-Kung prefix adder/subtractor with valid/ready handshake
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : input beat handshake (in_ready depends only on the output side)
//   in_a, in_b, in_sub    : operands; in_sub=1 computes a-b, otherwise a+b
//   out_valid/out_ready   : output beat handshake
//   out_s, out_cout       : sum/difference mod 2^WIDTH and MSB carry (borrow = ~out_cout)
//   out_ovf, out_zero     : signed overflow and zero-result flags
module bk_pipe_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int L = $clog2(WIDTH);
  logic             en;
  logic [WIDTH-1:0] bb, p1_d, g1_d;
  logic [WIDTH-1:0] p1_q, g1_q;
  logic             cin1_q, am1_q, bm1_q, v1_q;
  logic [WIDTH-1:0] ug_d, up_d;
  logic [WIDTH-1:0] ug2_q, up2_q, p2_q;
  logic             cin2_q, am2_q, bm2_q, v2_q;
  logic [WIDTH-1:0] c_d, s_d;
  logic             ovf_d;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  // The carry-in is folded into bit 0's generate so the tree needs no separate cin path.
  always_comb begin
    bb      = in_b ^ {WIDTH{in_sub}};
    p1_d    = in_a ^ bb;
    g1_d    = in_a & bb;
    g1_d[0] = g1_d[0] | (p1_d[0] & in_sub);
  end
  // Up-sweep: at level l node i (i+1 a multiple of 2^l) absorbs the span ending at i-2^(l-1).
  // Nodes whose span reaches bit 0 are grey cells: their P is never consumed.
  always_comb begin
    ug_d = g1_q;
    up_d = p1_q;
    for (int l = 1; l <= L; l++)
      for (int i = 0; i < WIDTH; i++)
        if ((i + 1) % (1 << l) == 0) begin
          ug_d[i] = ug_d[i] | (ug_d[i - (1 << (l - 1))] & up_d[i]);
          if (i + 1 != (1 << l))
            up_d[i] = up_d[i] & up_d[i - (1 << (l - 1))];
        end
  end
  // Down-sweep: midpoints of each level's blocks pick up the completed prefix just below them.
  always_comb begin
    c_d = ug2_q;
    for (int l = L - 1; l >= 1; l--)
      for (int i = 0; i < WIDTH; i++)
        if (i >= (1 << l) && (i + 1) % (1 << l) == (1 << (l - 1)))
          c_d[i] = c_d[i] | (c_d[i - (1 << (l - 1))] & up2_q[i]);
    s_d   = p2_q ^ {c_d[WIDTH-2:0], cin2_q};
    ovf_d = (am2_q == bm2_q) & (s_d[WIDTH-1] != am2_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (en) begin
      v1_q      <= in_valid;
      p1_q      <= p1_d;
      g1_q      <= g1_d;
      cin1_q    <= in_sub;
      am1_q     <= in_a[WIDTH-1];
      bm1_q     <= bb[WIDTH-1];
      v2_q      <= v1_q;
      ug2_q     <= ug_d;
      up2_q     <= up_d;
      p2_q      <= p1_q;
      cin2_q    <= cin1_q;
      am2_q     <= am1_q;
      bm2_q     <= bm1_q;
      out_valid <= v2_q;
      out_s     <= s_d;
      out_cout  <= c_d[WIDTH-1];
      out_ovf   <= ovf_d;
      out_zero  <= ~|s_d;
    end
  end
endmodule

// File: doc/bk_pipe_addsub.md
Name: bk_pipe_addsub

Overview:
- Pipelined 16-bit Brent-Kung prefix adder/subtractor. It is the subtract-capable, registered counterpart of the combinational Brent-Kung adder in the arithmetic library.
- Computes a+b or a-b (a + ~b + 1) with carry-in folded into bit 0 of the prefix tree.
- Three register stages, with a valid/ready handshake on input and output.
- Used by datapath blocks that need a registered add/sub with status flags at full throughput.

Parameters:
- WIDTH, 16, operand width. Must be a power of two, 4..64. Prefix depth is log2(WIDTH) up-sweep levels plus log2(WIDTH)-1 down-sweep levels.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  minuend / augend
- in_b  input  WIDTH  subtrahend / addend
- in_sub  input  1  1 = a-b, 0 = a+b
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- out_s  output  WIDTH  sum/difference, mod 2^WIDTH
- out_cout  output  1  carry-out of MSB. For subtract, borrow = ~out_cout.
- out_ovf  output  1  signed two's-complement overflow
- out_zero  output  1  out_s == 0

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits = 0; out_valid=0; out_s=0; out_cout=0; out_ovf=0; out_zero=0. Data registers in stages 1-2 are don't-care. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. No output beat is produced for them.
- Global advance enable: en = ~out_valid | out_ready. in_ready = en (combinational from out_valid/out_ready only; no dependency on in_valid).
- Input accept: occurs on a clk edge with in_valid & in_ready.
- When en=1 on an edge, all stages shift by one. Each stage's valid bit takes the previous stage's valid bit; stage-1 valid takes in_valid.
- Bubbles propagate as valid=0. Throughput is 1 beat/cycle when out_ready is held high.
- When en=0, every stage register holds, including out_* values. out_* must not change while out_valid=1 and out_ready=0.
- Latency: a beat accepted on edge N appears with out_valid=1 after edge N+2, i.e. 3 register stages with the output register being stage 3.
- Stage 1 (PG):
  - bb = in_b ^ {WIDTH{in_sub}}, cin = in_sub.
  - p0[i] = a[i]^bb[i], g0[i] = a[i]&bb[i].
  - Carry-in fold: g0'[0] = g0[0] | (p0[0]&cin).
  - Register p0, g0', cin, a[MSB], bb[MSB].
- Stage 2 (up-sweep): Brent-Kung up-sweep levels.
  - Black cell: G = Gk | (Gj & Pk), P = Pk & Pj, where k is the upper span and j the lower.
  - Grey cell (G only) where the lower span reaches bit 0.
  - Register the partial G/P vectors, p0, cin, and the MSB operand bits.
- Stage 3 (down-sweep + sum):
  - Down-sweep grey cells complete prefix carries C[i] = G[i:0].
  - s[0] = p0[0]^cin; s[i] = p0[i]^C[i-1] for i>=1.
  - cout = C[WIDTH-1].
  - ovf = (a_msb == bb_msb) & (s_msb != a_msb).
  - zero = ~|s.
  - Register all of these into out_*.
- Arithmetic: results wrap mod 2^WIDTH. No saturation. Add with in_sub=0 uses cin=0.
- Simultaneous events:
  - Output accepted and new input accepted on the same edge: both happen; the pipeline shifts.
  - in_valid=0 while en=1 inserts a bubble.
- Result must equal the behavioural reference {cout,s} = a + (sub ? ~b : b) + sub for every input.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_s=0x0000, all flags 0, in_ready=1 after release; no stale beat emerges.
- a=0x0005, b=0x0003, sub=1, out_ready=1 -> 3 cycles later out_s=0x0002, cout=1, ovf=0, zero=0.
- a=0x0000, b=0x0001, sub=1 -> out_s=0xFFFF, cout=0 (borrow), ovf=0; a=0x8000, b=0x0001, sub=1 -> out_s=0x7FFF, cout=1, ovf=1.
- a=0xFFFF, b=0x0001, sub=0 -> out_s=0x0000, cout=1, zero=1, ovf=0; a=0x7FFF, b=0x0001, sub=0 -> 0x8000, ovf=1.
- Back-to-back 4 beats (1-1, 2+2, 9-4, 0x1234+0x1111) with out_ready=0 from cycle 3 for 5 cycles -> in_ready=0 and out_* held at 0x0000; on release results 0x0000, 0x0004, 0x0005, 0x2345 in order, none lost or duplicated.
- Assert rst with 3 beats in flight -> out_valid=0 next cycle, those beats never appear; 10k random a/b/sub with random out_ready compared against the behavioural model.
